// File: rtl/decrypt_mux_fifo.sv
// N-channel selector for the decryption datapath: forwards the selected valid/ready
// stream into a show-ahead output FIFO and drains completely before switching channels.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_PASS  | active channel routed; pushes accepted while select matches
// ST_DRAIN | select changed; no pushes, FIFO empties, then new channel loads
module decrypt_mux_fifo #(
  parameter int D_WIDTH = 8,
  parameter int N_CH    = 3,
  parameter int DEPTH   = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        select_i,
  input  logic [N_CH*D_WIDTH-1:0] data_i,
  input  logic [N_CH-1:0]         valid_i,
  output logic [N_CH-1:0]         ready_o,
  output logic [D_WIDTH-1:0]      data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [SEL_W-1:0]        active_sel_o,
  output logic                    busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_PASS, ST_DRAIN} state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_active_sel;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [D_WIDTH-1:0] r_mem [DEPTH];

  logic               w_sel_ok;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [D_WIDTH-1:0] w_push_data;

  // An out-of-range active selection simply never grants ready.
  assign w_sel_ok = ({1'b0, r_active_sel} < (SEL_W+1)'(N_CH));
  assign w_accept = (r_state == ST_PASS) && (select_i == r_active_sel) &&
                    (r_count < CNT_W'(DEPTH)) && w_sel_ok && !rst;

  always_comb begin
    ready_o     = '0;
    w_push_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      ready_o[k] = w_accept && (r_active_sel == SEL_W'(k));
      if (ready_o[k]) begin
        w_push_data = data_i[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign w_push       = |(valid_i & ready_o);
  assign valid_o      = (r_count != '0) && !rst;
  assign w_pop        = valid_o && ready_i;
  assign data_o       = valid_o ? r_mem[r_rd_ptr] : '0;
  assign busy_o       = (r_state == ST_DRAIN) && !rst;
  assign active_sel_o = r_active_sel;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_PASS;
      r_active_sel <= '0;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        ST_PASS: begin
          if (select_i != r_active_sel) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Reload only once empty, so words of two ciphers never mix.
          if (r_count == '0) begin
            r_active_sel <= select_i;
            r_state      <= ST_PASS;
          end
        end
        default: r_state <= ST_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_mux_fifo.sv
// Scoreboard bench for decrypt_mux_fifo: a cycle model predicts ready/valid/busy and
// queues accepted words; the FIFO head is compared against the queue every cycle.
module tb_decrypt_mux_fifo;

  logic        clk;
  logic        rst;
  logic [1:0]  select_i;
  logic [23:0] data_i;
  logic [2:0]  valid_i;
  logic [2:0]  ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  active_sel_o;
  logic        busy_o;

  decrypt_mux_fifo #(.D_WIDTH(8), .N_CH(3), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .select_i     (select_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .active_sel_o (active_sel_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_q [$];
  logic       m_drain = 1'b0;
  logic [1:0] m_sel   = 2'd0;
  logic       last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic       exp_rdy;
    logic       exp_valid;
    logic [2:0] exp_ready;
    logic [7:0] word;
    int         cnt_pre;
    @(negedge clk);
    exp_rdy   = !m_drain && (select_i == m_sel) && (m_q.size() < 4) && (m_sel < 2'd3) && !rst;
    exp_ready = exp_rdy ? (3'b001 << m_sel) : 3'b000;
    exp_valid = (m_q.size() > 0) && !rst;
    chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("valid_o", 32'(valid_o), 32'(exp_valid));
    chk("data_o", 32'(data_o), exp_valid ? 32'(m_q[0]) : 32'd0);
    chk("busy_o", 32'(busy_o), 32'(m_drain && !rst));
    chk("active_sel_o", 32'(active_sel_o), 32'(m_sel));
    @(posedge clk);
    last_acc = exp_rdy && (m_sel < 2'd3) && valid_i[m_sel];
    cnt_pre  = m_q.size();
    if (rst) begin
      m_q.delete();
      m_drain  = 1'b0;
      m_sel    = 2'd0;
      last_acc = 1'b0;
    end else begin
      word = 8'(data_i >> (8 * m_sel));
      if (exp_valid && ready_i) void'(m_q.pop_front());
      if (last_acc) m_q.push_back(word);
      if (!m_drain) begin
        if (select_i != m_sel) m_drain = 1'b1;
      end else if (cnt_pre == 0) begin
        m_sel   = select_i;
        m_drain = 1'b0;
      end
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst = 1'b1; select_i = 2'd0; data_i = '0; valid_i = '0; ready_i = 1'b0;
    steps(2);
    rst = 1'b0;
    step();

    // 1: two words on ch0, streaming out
    ready_i = 1'b1;
    data_i[7:0] = 8'h41; valid_i = 3'b001; step();
    data_i[7:0] = 8'h42; step();
    valid_i = '0;
    steps(3);

    // 2: fill to full on ch1, then drain with one extra word pending
    select_i = 2'd1; steps(3);
    ready_i = 1'b0; idx = 0; valid_i = 3'b010;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      if (c == 10) ready_i = 1'b1;
      data_i[15:8] = 8'h10 + 8'(idx);
      step();
      if (last_acc) idx++;
    end
    chk("t2_all_accepted", 32'(idx), 32'd5);
    valid_i = '0; steps(6);

    // 3: switch away with three ch0 words queued
    select_i = 2'd0; steps(3);
    ready_i = 1'b0; valid_i = 3'b001;
    for (int w = 0; w < 3; w++) begin
      data_i[7:0] = 8'h20 + 8'(w); step();
    end
    valid_i = '0; select_i = 2'd2;
    steps(3);
    chk("t3_busy", 32'(busy_o), 32'd1);
    ready_i = 1'b1; steps(6);
    chk("t3_active_sel", 32'(active_sel_o), 32'd2);
    chk("t3_ready", 32'(ready_o), 32'b100);

    // 4: out-of-range select never accepts
    select_i = 2'd3; valid_i = 3'b111; data_i = 24'hA5B6C7;
    steps(25);
    chk("t4_active_sel", 32'(active_sel_o), 32'd3);
    chk("t4_ready", 32'(ready_o), 32'd0);
    chk("t4_valid", 32'(valid_o), 32'd0);
    valid_i = '0;

    // 5: steady push+pop at occupancy 2
    select_i = 2'd0; steps(3);
    ready_i = 1'b0; valid_i = 3'b001;
    data_i[7:0] = 8'h60; step();
    data_i[7:0] = 8'h61; step();
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      data_i[7:0] = 8'h62 + 8'(c); step();
    end
    chk("t5_occupancy", 32'(m_q.size()), 32'd2);
    valid_i = '0; steps(4);

    // 6: reset with three words queued
    ready_i = 1'b0; valid_i = 3'b001;
    for (int w = 0; w < 3; w++) begin
      data_i[7:0] = 8'h70 + 8'(w); step();
    end
    valid_i = '0; select_i = 2'd1; step();
    rst = 1'b1; step();
    rst = 1'b0; select_i = 2'd0;
    chk("t6_valid", 32'(valid_o), 32'd0);
    chk("t6_data", 32'(data_o), 32'd0);
    chk("t6_active_sel", 32'(active_sel_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    steps(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
